// File: rtl/digit_scan_controller.sv
// Seven-segment multiplex scanner: owns a refresh prescaler, steps one
// active-low anode through the enabled positions in increasing index order,
// presents the selected nibble and pulses frame_done when the scan wraps.
// Optional macro SCAN_DEADTIME_EN adds DEAD_CYCLES of anode blanking after
// every step.
module digit_scan_controller #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned PRESCALE    = 100000,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [3:0]                    digit_val,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || PRESCALE < 1 || DEAD_CYCLES < 1) begin : g_bad_param
        $error("digit_scan_controller: illegal parameter value");
    end

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       nxt_idx;
    logic                  step;
    logic                  blank;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [3:0]            val_d;
    logic                  frame_d;

    // Find the next enabled position after idx_q, wrapping; idx_q itself is last.
    always_comb begin
        int unsigned pos;
        logic        found;
        pos     = 0;
        found   = 1'b0;
        nxt_idx = idx_q;
        for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
            pos = int'(idx_q) + k;
            if (pos >= NUM_DIGITS) begin
                pos = pos - NUM_DIGITS;
            end
            if (!found && digit_mask[IdxW'(pos)]) begin
                found   = 1'b1;
                nxt_idx = IdxW'(pos);
            end
        end
    end

    // Prescaler and position next-state; an empty mask suppresses the step.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (en) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                step  = |digit_mask;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        idx_d   = step ? nxt_idx : idx_q;
        frame_d = step && (nxt_idx <= idx_q);
    end

`ifdef SCAN_DEADTIME_EN
    localparam int unsigned DeadW = $clog2(DEAD_CYCLES + 1);

    logic [DeadW-1:0] dead_q, dead_d;

    // Dead-time counter: reload on a step, count down only while enabled.
    always_comb begin
        dead_d = dead_q;
        if (step) begin
            dead_d = DeadW'(DEAD_CYCLES);
        end else if (en && dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end
        blank = (dead_d != '0);
    end

    // Dead-time counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Output next-state: anode and nibble follow the upcoming index and live inputs.
    always_comb begin
        onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
        anode_d = blank ? '1 : ~(onehot & digit_mask);
        val_d   = digits[{idx_d, 2'b00} +: 4];
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            anode      <= '1;
            digit_val  <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            anode      <= anode_d;
            digit_val  <= val_d;
            frame_done <= frame_d;
        end
    end

    assign digit_idx = idx_q;

endmodule
